// File: rtl/delta_update_applier_pkg.sv
// Shared types and helpers for the delta update applier.
package delta_update_applier_pkg;

  // Top-level control: INIT sweeps the vertex-delta RAM to zero, RUN applies updates.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_t;

  localparam int MISROUTE_W = 16;

  // Almost-full threshold: 16 entries of headroom for deep FIFOs; shallow FIFOs
  // keep 3 entries of headroom so the threshold stays meaningful.
  function automatic int prog_full_th(input int depth);
    return (depth > 16) ? depth - 16 : depth - 3;
  endfunction

endpackage

// File: rtl/update_fifo_ft.sv
// Synchronous first-word-fall-through FIFO with programmable almost-full.
// DEPTH must be a power of two (pointers wrap naturally).
module update_fifo_ft #(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 64,
  parameter int PROG_FULL_TH = 48
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             prog_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign push      = wr_en && !full;
  assign pop       = rd_en && !empty;
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign prog_full = (count >= (AW+1)'(PROG_FULL_TH));
  assign rd_data   = mem[rd_ptr];

  // Storage write; head is always visible on rd_data.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/delta_update_applier.sv
// Per-core receiver of the scheduler update stream: buffers updates, accumulates
// deltas into a local vertex-delta RAM and reports iteration completion.
//
// Handshakes: the update stream has no ready; the producer must stop sending
// while stage_full is high. A readout request (rd_en) is taken only in a cycle
// where rd_ready is high; while rd_en is held or a readout is in flight, FIFO
// pops stall so the readout owns the RAM read port.
module delta_update_applier
  import delta_update_applier_pkg::*;
#(
  parameter int V_ID_WIDTH      = 32,
  parameter int V_VALUE_WIDTH   = 32,
  parameter int ITERATION_WIDTH = 8,
  parameter int CORE_NUM        = 16,
  parameter int CORE_ID         = 0,
  parameter int LOCAL_AW        = 12,
  parameter int FIFO_DEPTH      = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [V_ID_WIDTH-1:0]      update_v_id,
  input  logic [V_VALUE_WIDTH-1:0]   update_v_value,
  input  logic                       update_v_valid,
  input  logic                       iteration_end,
  input  logic                       iteration_end_valid,
  input  logic [ITERATION_WIDTH-1:0] iteration_id,
  output logic                       stage_full,
  input  logic                       rd_en,
  input  logic [LOCAL_AW-1:0]        rd_addr,
  input  logic                       rd_clear,
  output logic                       rd_ready,
  output logic [V_VALUE_WIDTH-1:0]   rd_data,
  output logic                       rd_valid,
  output logic                       iteration_done,
  output logic [ITERATION_WIDTH-1:0] iteration_done_id,
  output logic [MISROUTE_W-1:0]      misroute_cnt,
  output logic                       overflow,
  output fsm_state_t                 fsm_state
);

  localparam int CW = $clog2(CORE_NUM);
  localparam int FW = V_ID_WIDTH + V_VALUE_WIDTH;
  localparam int TH = prog_full_th(FIFO_DEPTH);

  fsm_state_t                 state, state_next;
  logic [LOCAL_AW-1:0]        init_addr;
  logic [FW-1:0]              head;
  logic [V_ID_WIDTH-1:0]      head_id, vid_hi;
  logic [V_VALUE_WIDTH-1:0]   head_val;
  logic                       fifo_full, fifo_empty, fifo_prog_full;
  logic                       pop, owned, accept_upd, drop, rd_accept, end_in, done_cond;
  logic [LOCAL_AW-1:0]        local_addr, ram_raddr, ram_waddr, s1_addr;
  logic [V_VALUE_WIDTH-1:0]   ram_rdata, ram_wdata, fwd_data, p1_sum;
  logic                       ram_we;
  logic [V_VALUE_WIDTH-1:0]   mem [2**LOCAL_AW];
  logic                       p1_valid;
  logic [LOCAL_AW-1:0]        p1_addr;
  logic [V_VALUE_WIDTH-1:0]   p1_delta;
  logic                       lw_valid;
  logic [LOCAL_AW-1:0]        lw_addr;
  logic [V_VALUE_WIDTH-1:0]   lw_data;
  logic                       rd_s1_valid, rd_s1_clear;
  logic [LOCAL_AW-1:0]        rd_s1_addr;
  logic                       pending;
  logic [ITERATION_WIDTH-1:0] pend_id;

  update_fifo_ft #(
    .WIDTH        (FW),
    .DEPTH        (FIFO_DEPTH),
    .PROG_FULL_TH (TH)
  ) u_fifo (
    .clk       (clk),
    .srst      (rst),
    .wr_en     (update_v_valid),
    .wr_data   ({update_v_id, update_v_value}),
    .rd_en     (pop),
    .rd_data   (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .prog_full (fifo_prog_full)
  );

  assign head_id    = head[FW-1:V_VALUE_WIDTH];
  assign head_val   = head[V_VALUE_WIDTH-1:0];
  assign vid_hi     = head_id >> CW;
  assign local_addr = vid_hi[LOCAL_AW-1:0];
  assign owned      = (head_id[CW-1:0] == CW'(CORE_ID)) && ((vid_hi >> LOCAL_AW) == '0);

  assign fsm_state  = state;
  assign stage_full = (state == ST_INIT) || fifo_prog_full;
  assign rd_ready   = (state == ST_RUN) && fifo_empty && !p1_valid;
  assign rd_accept  = rd_en && rd_ready;
  assign pop        = (state == ST_RUN) && !fifo_empty && !rd_en && !rd_s1_valid;
  assign accept_upd = pop && owned;
  assign drop       = pop && !owned;
  assign ram_raddr  = rd_accept ? rd_addr : local_addr;

  // The RAM is read-first, so a write landing in the read cycle is invisible;
  // forward the previous cycle's write when it targets the address just read.
  assign s1_addr  = rd_s1_valid ? rd_s1_addr : p1_addr;
  assign fwd_data = (lw_valid && (lw_addr == s1_addr)) ? lw_data : ram_rdata;
  assign p1_sum   = fwd_data + p1_delta;

  assign end_in    = iteration_end && iteration_end_valid;
  assign done_cond = pending && (state == ST_RUN) && fifo_empty && !p1_valid
                     && !update_v_valid && !end_in;

  // FSM state register and INIT sweep address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      init_addr <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) init_addr <= init_addr + 1'b1;
    end
  end

  // Next state: leave INIT once the last RAM entry has been zeroed.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (init_addr == '1) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // Write-port arbitration: INIT zeroing, accumulate, or readout clear.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (state == ST_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_addr;
    end else if (p1_valid) begin
      ram_we    = 1'b1;
      ram_waddr = p1_addr;
      ram_wdata = p1_sum;
    end else if (rd_s1_valid && rd_s1_clear) begin
      ram_we    = 1'b1;
      ram_waddr = rd_s1_addr;
    end
  end

  // Vertex-delta RAM: simple dual port, one-cycle read-first.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  // Accumulate stage and last-write record for forwarding.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid <= 1'b0;
      lw_valid <= 1'b0;
    end else begin
      p1_valid <= accept_upd;
      lw_valid <= ram_we;
    end
    p1_addr  <= local_addr;
    p1_delta <= head_val;
    lw_addr  <= ram_waddr;
    lw_data  <= ram_wdata;
  end

  // Readout pipeline: request, RAM read, registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_s1_valid <= 1'b0;
      rd_s1_clear <= 1'b0;
      rd_s1_addr  <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      rd_s1_valid <= rd_accept;
      rd_s1_clear <= rd_accept && rd_clear;
      rd_s1_addr  <= rd_addr;
      rd_valid    <= rd_s1_valid;
      if (rd_s1_valid) rd_data <= fwd_data;
    end
  end

  // Iteration-end tracking and the completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending           <= 1'b0;
      pend_id           <= '0;
      iteration_done    <= 1'b0;
      iteration_done_id <= '0;
    end else begin
      iteration_done <= done_cond;
      if (done_cond) iteration_done_id <= pend_id;
      if (end_in) begin
        pending <= 1'b1;
        pend_id <= iteration_id;
      end else if (done_cond) begin
        pending <= 1'b0;
      end
    end
  end

  // Error counters: misrouted drops and writes into a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      misroute_cnt <= '0;
      overflow     <= 1'b0;
    end else begin
      if (drop && (misroute_cnt != '1)) misroute_cnt <= misroute_cnt + 1'b1;
      if (update_v_valid && fifo_full)  overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_delta_update_applier.sv
// Directed bench for delta_update_applier (4 cores, core 1, 16-entry RAM/FIFO).
module tb_delta_update_applier;
  import delta_update_applier_pkg::*;

  localparam int VIW = 32;
  localparam int VVW = 32;
  localparam int ITW = 8;
  localparam int AW  = 4;

  logic            clk;
  logic            rst;
  logic [VIW-1:0]  update_v_id;
  logic [VVW-1:0]  update_v_value;
  logic            update_v_valid;
  logic            iteration_end;
  logic            iteration_end_valid;
  logic [ITW-1:0]  iteration_id;
  logic            stage_full;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic            rd_clear;
  logic            rd_ready;
  logic [VVW-1:0]  rd_data;
  logic            rd_valid;
  logic            iteration_done;
  logic [ITW-1:0]  iteration_done_id;
  logic [15:0]     misroute_cnt;
  logic            overflow;
  fsm_state_t      fsm_state;

  int checks   = 0;
  int failures = 0;

  delta_update_applier #(
    .V_ID_WIDTH      (VIW),
    .V_VALUE_WIDTH   (VVW),
    .ITERATION_WIDTH (ITW),
    .CORE_NUM        (4),
    .CORE_ID         (1),
    .LOCAL_AW        (AW),
    .FIFO_DEPTH      (16)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .update_v_id         (update_v_id),
    .update_v_value      (update_v_value),
    .update_v_valid      (update_v_valid),
    .iteration_end       (iteration_end),
    .iteration_end_valid (iteration_end_valid),
    .iteration_id        (iteration_id),
    .stage_full          (stage_full),
    .rd_en               (rd_en),
    .rd_addr             (rd_addr),
    .rd_clear            (rd_clear),
    .rd_ready            (rd_ready),
    .rd_data             (rd_data),
    .rd_valid            (rd_valid),
    .iteration_done      (iteration_done),
    .iteration_done_id   (iteration_done_id),
    .misroute_cnt        (misroute_cnt),
    .overflow            (overflow),
    .fsm_state           (fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one update for one cycle (called at a negedge, returns at the next).
  task automatic push(input logic [31:0] id, input logic [31:0] val);
    update_v_id    = id;
    update_v_value = val;
    update_v_valid = 1'b1;
    @(negedge clk);
    update_v_valid = 1'b0;
  endtask

  // Readout with bounded wait for rd_ready; data sampled 2 cycles after acceptance.
  task automatic do_read(input int addr, input bit clr, output logic [31:0] data);
    int n;
    n = 0;
    while (!rd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rd_ready_wait", {31'd0, rd_ready}, 32'd1);
    rd_en    = 1'b1;
    rd_addr  = AW'(addr);
    rd_clear = clr;
    @(negedge clk);
    rd_en    = 1'b0;
    rd_clear = 1'b0;
    @(negedge clk);
    check("rd_valid_latency", {31'd0, rd_valid}, 32'd1);
    data = rd_data;
  endtask

  initial begin
    logic [31:0] d;
    int pulses;
    int first;
    logic [31:0] got_id;

    rst = 1'b1;
    update_v_id = '0; update_v_value = '0; update_v_valid = 1'b0;
    iteration_end = 1'b0; iteration_end_valid = 1'b0; iteration_id = '0;
    rd_en = 1'b0; rd_addr = '0; rd_clear = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_stage_full", {31'd0, stage_full}, 32'd1);
    check("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_done", {31'd0, iteration_done}, 32'd0);
    check("rst_misroute", {16'd0, misroute_cnt}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ST_INIT));

    // INIT sweep: 16 cycles
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("init_stage_full", {31'd0, stage_full}, 32'd1);
    check("init_state", 32'(fsm_state), 32'(ST_INIT));
    @(negedge clk);
    check("run_stage_full", {31'd0, stage_full}, 32'd0);
    check("run_state", 32'(fsm_state), 32'(ST_RUN));
    for (int a = 0; a < 16; a++) begin
      do_read(a, 1'b0, d);
      check("init_zero", d, 32'd0);
    end

    // Back-to-back same-vertex accumulation: 3 + 4 - 2 = 5 at addr 1
    push(32'd5, 32'd3);
    push(32'd5, 32'd4);
    push(32'd5, 32'hFFFF_FFFE);
    repeat (6) @(negedge clk);
    do_read(1, 1'b1, d);
    check("accum_v5", d, 32'd5);
    do_read(1, 1'b0, d);
    check("clear_v5", d, 32'd0);

    // Misroutes: foreign core (6) and out-of-range (69 -> local 17)
    push(32'd6, 32'd100);
    push(32'd69, 32'd100);
    repeat (4) @(negedge clk);
    check("misroute_cnt", {16'd0, misroute_cnt}, 32'd2);
    do_read(1, 1'b0, d);
    check("misroute_ram_addr1", d, 32'd0);
    check("no_overflow_yet", {31'd0, overflow}, 32'd0);

    // Backpressure and overflow with pops held off by a readout request
    rd_en = 1'b1; rd_addr = '0; rd_clear = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 12; i++) push(32'd9, 32'd1);
    check("below_prog_full", {31'd0, stage_full}, 32'd0);
    push(32'd9, 32'd1);
    check("prog_full", {31'd0, stage_full}, 32'd1);
    for (int i = 0; i < 3; i++) push(32'd9, 32'd1);
    check("full_no_overflow", {31'd0, overflow}, 32'd0);
    push(32'd9, 32'd1);
    check("overflow_set", {31'd0, overflow}, 32'd1);
    rd_en = 1'b0;
    repeat (25) @(negedge clk);
    do_read(2, 1'b0, d);
    check("applied_16", d, 32'd16);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);

    // Iteration end in the same cycle as the last of three updates
    push(32'd13, 32'd10);
    push(32'd13, 32'd20);
    iteration_end = 1'b1; iteration_end_valid = 1'b1; iteration_id = 8'd7;
    push(32'd13, 32'd30);
    iteration_end = 1'b0; iteration_end_valid = 1'b0; iteration_id = '0;
    pulses = 0; first = -1; got_id = '0;
    for (int i = 1; i <= 20; i++) begin
      if (iteration_done) begin
        pulses++;
        if (first < 0) first = i;
        got_id = {24'd0, iteration_done_id};
      end
      @(negedge clk);
    end
    check("done_pulses", pulses, 32'd1);
    check("done_id", got_id, 32'd7);
    check("done_after_write", {31'd0, (first >= 3)}, 32'd1);
    do_read(3, 1'b0, d);
    check("iter_sum_v13", d, 32'd60);

    // Reset mid-stream with a pending end and queued updates
    rd_en = 1'b1; rd_addr = '0;
    @(negedge clk);
    push(32'd5, 32'd1);
    push(32'd5, 32'd2);
    iteration_end = 1'b1; iteration_end_valid = 1'b1; iteration_id = 8'd9;
    push(32'd6, 32'd1);
    iteration_end = 1'b0; iteration_end_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; rd_en = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_misroute", {16'd0, misroute_cnt}, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    check("mid_rst_stage_full", {31'd0, stage_full}, 32'd1);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (iteration_done) pulses++;
      @(negedge clk);
    end
    check("mid_rst_no_done", pulses, 32'd0);
    check("mid_rst_state", 32'(fsm_state), 32'(ST_RUN));
    do_read(1, 1'b0, d);
    check("mid_rst_addr1", d, 32'd0);
    do_read(2, 1'b0, d);
    check("mid_rst_addr2", d, 32'd0);
    do_read(3, 1'b0, d);
    check("mid_rst_addr3", d, 32'd0);
    check("mid_rst_misroute_after", {16'd0, misroute_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
